usb_rx_decoder: RTL

USB_RX_DECODER -- requirements
Module: usb_rx_decoder

---
 rtl/usb_rx_decoder.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_rx_decoder.sv
// -----------------------------------------------------------------------------
// usb_rx_decoder
// Full-speed USB receive decoder.  Recovers bit timing from the oversampled
// D+/D- lines, NRZI-decodes each bit, strips stuff bits, assembles bytes
// LSB-first and frames packets between SYNC and EOP.
//
// Ports
//   USB_Clk      in   48 MHz receive clock, rising edge
//   Reset        in   synchronous active-high reset
//   DP, DN       in   line samples, already synchronised to USB_Clk
//   Data         out  received byte, meaningful while Data_Valid=1
//   Data_Valid   out  one-cycle strobe per assembled byte
//   Packet_Start out  one-cycle strobe when SYNC completes
//   Packet_End   out  one-cycle strobe when EOP or abort recovery completes
//   Error        out  one-cycle strobe on stuff, SE1 or partial-byte error
//   Active       out  high from Packet_Start through Packet_End inclusive
// -----------------------------------------------------------------------------
module usb_rx_decoder #(
   parameter int OVERSAMPLE = 4
) (
   input  logic       USB_Clk,
   input  logic       Reset,
   input  logic       DP,
   input  logic       DN,
   output logic [7:0] Data,
   output logic       Data_Valid,
   output logic       Packet_Start,
   output logic       Packet_End,
   output logic       Error,
   output logic       Active
);

   localparam int PHASE_W = $clog2(OVERSAMPLE);
   // Mid-bit sample point: the line has been stable for three cycles here.
   localparam logic [PHASE_W-1:0] SAMPLE_PHASE = PHASE_W'(OVERSAMPLE / 2);

   // Line states as {DP, DN}
   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_K   = 2'b01;
   localparam logic [1:0] LS_J   = 2'b10;
   localparam logic [1:0] LS_SE1 = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SYNC  = 3'd1,
      ST_DATA  = 3'd2,
      ST_EOP   = 3'd3,
      ST_ABORT = 3'd4
   } state_e;

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   state_e              state_q;
   logic [PHASE_W-1:0]  phase_q;
   logic [1:0]          line_q;      // line state seen on the previous cycle
   logic [1:0]          prev_q;      // previous sampled J/K, NRZI reference
   logic [2:0]          zero_cnt_q;  // SYNC zeros, saturating
   logic [2:0]          ones_cnt_q;  // consecutive data ones for destuffing
   logic [2:0]          bit_cnt_q;   // data bits of the current byte
   logic [6:0]          shift_q;     // first seven bits of the byte, LSB at [0] when full
   logic                eop_err_q;   // EOP arrived on a partial byte
   logic                seen_se0_q;  // ABORT has sampled SE0 at least once
   logic [7:0]          data_q;
   logic                data_valid_q;
   logic                pkt_start_q;
   logic                pkt_end_q;
   logic                error_q;
   logic                active_q;

   // ---------------------------------------------------------------------
   // Combinational decode of the current cycle
   // ---------------------------------------------------------------------
   logic [1:0]          line_s;
   logic [PHASE_W-1:0]  phase_d;
   logic                sample_s;
   logic                samp_j_s;
   logic                samp_k_s;
   logic                samp_se0_s;
   logic                se1_s;
   logic                dec_bit_s;

   // Line-state decode, bit-phase recovery and NRZI decode
   always_comb begin
      line_s = {DP, DN};
      // Any line transition re-aligns the bit phase; otherwise free-run and wrap.
      if (line_s != line_q) begin
         phase_d = '0;
      end else begin
         phase_d = phase_q + PHASE_W'(1);
      end
      sample_s   = (phase_d == SAMPLE_PHASE);
      samp_j_s   = sample_s && (line_s == LS_J);
      samp_k_s   = sample_s && (line_s == LS_K);
      samp_se0_s = sample_s && (line_s == LS_SE0);
      // SE1 is illegal on any cycle, not only at the sample point.
      se1_s      = (line_s == LS_SE1);
      // NRZI: no change from the previous sampled level means a 1.
      dec_bit_s  = (line_s == prev_q);
   end

   // Protocol FSM, bit/byte assembly and registered strobes
   always_ff @(posedge USB_Clk) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         phase_q      <= '0;
         line_q       <= LS_J;
         prev_q       <= LS_J;
         zero_cnt_q   <= 3'd0;
         ones_cnt_q   <= 3'd0;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 7'h00;
         eop_err_q    <= 1'b0;
         seen_se0_q   <= 1'b0;
         data_q       <= 8'h00;
         data_valid_q <= 1'b0;
         pkt_start_q  <= 1'b0;
         pkt_end_q    <= 1'b0;
         error_q      <= 1'b0;
         active_q     <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         line_q       <= line_s;
         data_valid_q <= 1'b0;
         pkt_start_q  <= 1'b0;
         pkt_end_q    <= 1'b0;
         error_q      <= 1'b0;
         // Active drops the cycle after Packet_End has been shown.
         active_q     <= active_q & ~pkt_end_q;

         case (state_q)
            ST_IDLE: begin
               prev_q     <= LS_J;
               zero_cnt_q <= 3'd0;
               ones_cnt_q <= 3'd0;
               bit_cnt_q  <= 3'd0;
               // SE0 and SE1 are ignored here; only a K starts a SYNC.
               if (samp_k_s) begin
                  prev_q  <= LS_K;
                  state_q <= ST_SYNC;
               end
            end

            ST_SYNC: begin
               if (se1_s) begin
                  error_q    <= 1'b1;
                  seen_se0_q <= 1'b0;
                  state_q    <= ST_ABORT;
               end else if (samp_se0_s) begin
                  prev_q  <= LS_J;
                  state_q <= ST_IDLE;
               end else if (samp_j_s || samp_k_s) begin
                  prev_q <= line_s;
                  if (!dec_bit_s) begin
                     if (zero_cnt_q != 3'd7) begin
                        zero_cnt_q <= zero_cnt_q + 3'd1;
                     end
                  end else if (zero_cnt_q >= 3'd3) begin
                     ones_cnt_q  <= 3'd0;
                     bit_cnt_q   <= 3'd0;
                     pkt_start_q <= 1'b1;
                     active_q    <= 1'b1;
                     state_q     <= ST_DATA;
                  end else begin
                     // Too few alternations to be a real SYNC.
                     prev_q  <= LS_J;
                     state_q <= ST_IDLE;
                  end
               end
            end

            ST_DATA: begin
               if (se1_s) begin
                  error_q    <= 1'b1;
                  seen_se0_q <= 1'b0;
                  state_q    <= ST_ABORT;
               end else if (samp_se0_s) begin
                  eop_err_q <= (bit_cnt_q != 3'd0);
                  state_q   <= ST_EOP;
               end else if (samp_j_s || samp_k_s) begin
                  prev_q <= line_s;
                  if (ones_cnt_q == 3'd6) begin
                     // Bit after six ones must be a stuffed 0.
                     if (dec_bit_s) begin
                        error_q    <= 1'b1;
                        seen_se0_q <= 1'b0;
                        state_q    <= ST_ABORT;
                     end else begin
                        ones_cnt_q <= 3'd0;
                     end
                  end else begin
                     ones_cnt_q <= dec_bit_s ? (ones_cnt_q + 3'd1) : 3'd0;
                     shift_q    <= {dec_bit_s, shift_q[6:1]};
                     // 3-bit counter wraps to 0 after the eighth bit.
                     bit_cnt_q  <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        data_q       <= {dec_bit_s, shift_q};
                        data_valid_q <= 1'b1;
                     end
                  end
               end
            end

            ST_EOP: begin
               if (se1_s) begin
                  error_q    <= 1'b1;
                  seen_se0_q <= 1'b0;
                  state_q    <= ST_ABORT;
               end else if (samp_j_s) begin
                  pkt_end_q <= 1'b1;
                  error_q   <= eop_err_q;
                  prev_q    <= LS_J;
                  state_q   <= ST_IDLE;
               end else if (samp_k_s) begin
                  error_q    <= 1'b1;
                  seen_se0_q <= 1'b0;
                  state_q    <= ST_ABORT;
               end
            end

            ST_ABORT: begin
               // Recover only on a J that follows an SE0 seen in this state.
               if (samp_se0_s) begin
                  seen_se0_q <= 1'b1;
               end else if (samp_j_s && seen_se0_q) begin
                  pkt_end_q <= 1'b1;
                  prev_q    <= LS_J;
                  state_q   <= ST_IDLE;
               end
            end

            default: begin
               prev_q  <= LS_J;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign Data         = data_q;
   assign Data_Valid   = data_valid_q;
   assign Packet_Start = pkt_start_q;
   assign Packet_End   = pkt_end_q;
   assign Error        = error_q;
   assign Active       = active_q;

endmodule
